// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the boot program loader
package program_loader_pkg;

  // Frame parser states; S_RUN and S_ERROR only leave on reset
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_RUN,
    S_ERROR
  } state_t;

  // Modulo-256 sum of every frame byte, CHK included, must land here
  localparam logic [7:0] CHK_OK = 8'h00;

  // Byte counts of the frame fields
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 2;
  localparam int CHK_BYTES  = 1;

  // Total bytes in a frame carrying n_words instruction words
  function automatic int frame_bytes(input int n_words);
    return LEN_BYTES + WORD_BYTES * n_words + CHK_BYTES;
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit modulo-256 byte accumulator with clear and add-enable
module loader_checksum (
  input  logic       i_clk,
  input  logic       i_clear,
  input  logic       i_add_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  // Clear wins over add so a reset abandons any byte arriving on the same edge
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction ROM loader with CPU reset hold
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [15:0]       o_rom_wdata,
  output logic              o_cpu_reset,
  output logic              o_loaded,
  output logic              o_error
);

  localparam logic [16:0] MAX_LEN = MAX_WORDS[16:0];

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_len_hi;
  logic [15:0]        r_len;
  logic [7:0]         r_hi;
  logic [15:0]        r_idx;
  logic               r_rom_we;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [15:0]        r_rom_wdata;
  logic               w_accept;
  logic [7:0]         w_sum;
  logic [7:0]         w_chk_sum;
  logic [15:0]        w_len_word;
  logic               w_len_over;
  logic               w_last_word;

  assign o_rx_ready  = (r_state != S_RUN) && (r_state != S_ERROR);
  assign w_accept    = i_rx_valid && o_rx_ready;
  assign w_chk_sum   = w_sum + i_rx_data;
  assign w_len_word  = {r_len_hi, i_rx_data};
  assign w_len_over  = {1'b0, w_len_word} > MAX_LEN;
  assign w_last_word = (r_idx == (r_len - 16'd1));

  loader_checksum u_checksum (
    .i_clk    (i_clk),
    .i_clear  (i_reset),
    .i_add_en (w_accept),
    .i_data   (i_rx_data),
    .o_sum    (w_sum)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_LEN_HI;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; every transition is gated by an accepted byte
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_LEN_HI:  w_state_next = S_LEN_LO;
        S_LEN_LO: begin
          if (w_len_over) begin
            w_state_next = S_ERROR;
          end else if (w_len_word == 16'd0) begin
            w_state_next = S_CHK;
          end else begin
            w_state_next = S_DATA_HI;
          end
        end
        S_DATA_HI: w_state_next = S_DATA_LO;
        S_DATA_LO: w_state_next = w_last_word ? S_CHK : S_DATA_HI;
        S_CHK:     w_state_next = (w_chk_sum == CHK_OK) ? S_RUN : S_ERROR;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // Length capture, word assembly and the registered ROM write port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len_hi    <= 8'h00;
      r_len       <= 16'h0000;
      r_hi        <= 8'h00;
      r_idx       <= 16'h0000;
      r_rom_we    <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_wdata <= 16'h0000;
    end else begin
      r_rom_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_LEN_HI:  r_len_hi <= i_rx_data;
          S_LEN_LO:  r_len    <= w_len_word;
          S_DATA_HI: r_hi     <= i_rx_data;
          S_DATA_LO: begin
            r_rom_we    <= 1'b1;
            r_rom_addr  <= r_idx[ADDR_W-1:0];
            r_rom_wdata <= {r_hi, i_rx_data};
            r_idx       <= r_idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rom_we    = r_rom_we;
  assign o_rom_addr  = r_rom_addr;
  assign o_rom_wdata = r_rom_wdata;
  assign o_cpu_reset = (r_state != S_RUN);
  assign o_loaded    = (r_state == S_RUN);
  assign o_error     = (r_state == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int ADDR_W = 15;
  localparam int MAXW   = 4;

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              loaded;
  logic              error;

  int checks = 0;
  int errors = 0;

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_rx_ready  (rx_ready),
    .o_rom_we    (rom_we),
    .o_rom_addr  (rom_addr),
    .o_rom_wdata (rom_wdata),
    .o_cpu_reset (cpu_reset),
    .o_loaded    (loaded),
    .o_error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame model: byte position within the frame decides its meaning
  bit          mv = 0;
  int          m_pos, m_len, m_status;   // status 0 loading, 1 running, 2 rejected
  logic [7:0]  m_sum, m_lenhi, m_hi;
  bit          exp_we;
  int          exp_addr;
  logic [15:0] exp_wdata;

  task automatic model_byte(input logic [7:0] b);
    int k;
    m_sum = m_sum + b;
    if (m_pos == 0) begin
      m_lenhi = b;
    end else if (m_pos == 1) begin
      m_len = {m_lenhi, b};
      if (m_len > MAXW) m_status = 2;
    end else if (m_pos == frame_bytes(m_len) - CHK_BYTES) begin
      m_status = (m_sum == CHK_OK) ? 1 : 2;
    end else begin
      k = m_pos - LEN_BYTES;
      if (k % 2 == 0) begin
        m_hi = b;
      end else begin
        exp_we    = 1;
        exp_addr  = k / 2;
        exp_wdata = {m_hi, b};
      end
    end
    m_pos++;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mv = 1; m_pos = 0; m_len = 0; m_status = 0; m_sum = 0; exp_we = 0;
    end else begin
      exp_we = 0;
      if (rx_valid && m_status == 0) model_byte(rx_data);
    end
  end

  // DUT writes observed since the last log clear, for literal checks
  int          log_addr[$];
  logic [15:0] log_data[$];

  always @(negedge clk) begin
    if (mv) begin
      check("rx_ready", rx_ready, m_status == 0);
      check("rom_we", rom_we, exp_we);
      if (rom_we && exp_we) begin
        check("rom_addr", rom_addr, exp_addr);
        check("rom_wdata", rom_wdata, exp_wdata);
      end
      check("cpu_reset", cpu_reset, m_status != 1);
      check("loaded", loaded, m_status == 1);
      check("error", error, m_status == 2);
      if (rom_we) begin
        log_addr.push_back(int'(rom_addr));
        log_data.push_back(rom_wdata);
      end
    end
  end

  task automatic do_reset(input logic hold_valid);
    reset = 1; rx_valid = hold_valid; rx_data = 8'h00;
    @(posedge clk); #1;
    reset = 0; rx_valid = 0;
    log_addr.delete(); log_data.delete();
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_idle);
    foreach (bytes[i]) begin
      rx_valid = 0;
      repeat ($urandom_range(0, max_idle)) @(posedge clk);
      #1;
      rx_valid = 1; rx_data = bytes[i];
      @(posedge clk); #1;
    end
    rx_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwrites"}, log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check({tag, "_addr0"}, log_addr[0], 0);
      check({tag, "_data0"}, log_data[0], 16'h0005);
      check({tag, "_addr1"}, log_addr[1], 1);
      check({tag, "_data1"}, log_data[1], 16'hEC10);
    end
    check({tag, "_loaded"}, loaded, 1);
    check({tag, "_cpu_reset"}, cpu_reset, 0);
  endtask

  logic [7:0] good[$];
  logic [7:0] bad[$];

  initial begin
    reset = 1; rx_valid = 0; rx_data = 8'h00;
    @(posedge clk); #1;
    do_reset(1'b0);

    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_wdata", rom_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_error", error, 0);
    check("rst_rx_ready", rx_ready, 1);

    good = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hFD};
    bad  = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hFE};

    // Two-word load, back to back; release visible right after CHK edge
    send_frame(good, 0);
    check("two_loaded_n1", loaded, 1);
    check("two_error", error, 0);
    idle(2);
    check_two_word("two");
    rx_valid = 1; rx_data = 8'h55;
    idle(5);
    rx_valid = 0;
    check("run_hold_nwrites", log_addr.size(), 2);

    // Empty program
    do_reset(1'b0);
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    check("empty_loaded", loaded, 1);
    idle(2);
    check("empty_nwrites", log_addr.size(), 0);

    // Bad checksum
    do_reset(1'b0);
    send_frame(bad, 0);
    check("bad_error", error, 1);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_loaded", loaded, 0);
    send_frame('{8'h00, 8'h00, 8'h00}, 1);
    check("bad_rx_ready", rx_ready, 0);
    check("bad_sticky", error, 1);

    // Length overflow with MAX_WORDS=4
    do_reset(1'b0);
    send_frame('{8'h00, 8'h05}, 0);
    check("ovf_error", error, 1);
    send_frame('{8'h00, 8'h01, 8'h22}, 0);
    check("ovf_nwrites", log_addr.size(), 0);

    // Exactly MAX_WORDS words is accepted
    do_reset(1'b0);
    send_frame('{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22,
                 8'h33, 8'h33, 8'h44, 8'h44, 8'hA8}, 0);
    idle(1);
    check("max_loaded", loaded, 1);
    check("max_nwrites", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("max_addr3", log_addr[3], 3);
      check("max_data3", log_data[3], 16'h4444);
    end

    // Stall tolerance
    do_reset(1'b0);
    send_frame(good, 3);
    idle(2);
    check_two_word("stall");

    // Reset mid-frame, with a byte presented during the reset cycle
    do_reset(1'b0);
    send_frame('{8'h00, 8'h02, 8'h00}, 0);
    do_reset(1'b1);
    send_frame(good, 1);
    idle(2);
    check_two_word("midrst");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the CPU's instruction path. It receives a framed byte stream, assembles 16-bit instruction words, and writes them to instruction ROM at consecutive addresses from 0. It holds the CPU in reset until a complete frame with a valid checksum has been loaded. On a checksum or length error it latches an error flag and never releases the CPU.

## Interface
- `ADDR_W`, default 15: ROM address width; matches the 15-bit `pc`.
- `MAX_WORDS`, default 32768: maximum accepted word count.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `rx_valid`  in  1: byte available on `rx_data`.
- `rx_data`  in  8: incoming byte.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `rom_we`  out  1: one-cycle ROM write strobe.
- `rom_addr`  out  ADDR_W: ROM word address.
- `rom_wdata`  out  16: instruction word to write.
- `cpu_reset`  out  1: drives the CPU `reset`; high until the load succeeds.
- `loaded`  out  1: frame accepted; CPU running.
- `error`  out  1: frame rejected; sticky until `reset`.

## Operation
- Frame format: `LEN_HI`, `LEN_LO`, then LEN×(`DATA_HI`, `DATA_LO`), then `CHK`. All fields are big-endian.
- Byte accepted ⇔ `rx_valid && rx_ready` on a rising edge. `rx_ready` is combinational from the state: 1 in the load states, 0 in RUN and ERROR.
- States and transitions:
  - S_LEN_HI → S_LEN_LO.
  - S_LEN_LO:
    - LEN > MAX_WORDS → S_ERROR.
    - LEN == 0 → S_CHK.
    - otherwise → S_DATA_HI.
  - S_DATA_HI → S_DATA_LO.
  - S_DATA_LO:
    - word index == LEN−1 → S_CHK.
    - otherwise → S_DATA_HI.
  - S_CHK:
    - sum ok → S_RUN.
    - otherwise → S_ERROR.
  - S_RUN and S_ERROR are terminal until `reset`.
- Checksum rule: an 8-bit accumulator sums every accepted byte, including the length bytes and `CHK`, modulo 256. The frame is valid iff the final sum is 0x00.
- Word assembly:
  - The `DATA_HI` byte is stored in a holding register.
  - On `DATA_LO` acceptance, `rom_wdata` = {hi, lo} and `rom_addr` = word index.
  - After the write, the word index increments. It is 16 bits wide internally; `rom_addr` carries its low ADDR_W bits.
- Words are written before the checksum is verified. On error the ROM contents are don't-care, because the CPU is never released.
- Bytes presented while in S_RUN or S_ERROR are ignored (`rx_ready` = 0).

## Timing
- Reset values, applied on the cycle after `reset` is sampled high:
  - state = S_LEN_HI.
  - `rom_we`=0, `rom_addr`=0, `rom_wdata`=0.
  - `cpu_reset`=1, `loaded`=0, `error`=0.
  - checksum = 0, word index = 0.
  - `rx_ready`=1 once `reset` is low.
- `rom_we`, `rom_addr`, `rom_wdata` are registered:
  - `DATA_LO` accepted at edge N → `rom_we`=1 for exactly the cycle after N.
  - `rom_we` is 0 otherwise.
- `CHK` accepted at edge N:
  - Valid sum: `cpu_reset`=0 and `loaded`=1 from edge N+1. The CPU fetches `pc`=0 on the cycle after that.
  - Invalid sum: `error`=1 from edge N+1.
- Length overflow: `error`=1 from the edge after `LEN_LO` is accepted.
- Throughput: one byte per cycle max. Any number of idle cycles is allowed between bytes.
- Reset mid-frame: the in-progress frame is abandoned and all counters are cleared. The next byte is treated as `LEN_HI`. Reset dominates any simultaneous byte acceptance.
- Reset while in S_RUN: `cpu_reset` reasserts and a new load is required.

## Structure
- The package `program_loader_pkg` holds:
  - the state enum,
  - `CHK_OK` = 8'h00,
  - the frame byte-count constants.
- One sub-module: `loader_checksum`, an 8-bit modulo-256 accumulator with a synchronous clear and an add-enable.
- Everything else (FSM, holding register, word counter, output registers) lives in `program_loader`.

## Test plan
- **Two-word load:** bytes 00 02 00 05 EC 10 FD → two writes: (addr 0, 0x0005) and (addr 1, 0xEC10). After FD is accepted, `cpu_reset`=0 and `loaded`=1 on the next cycle. `error`=0.
- **Empty program:** bytes 00 00 00 → no `rom_we` pulse; `loaded`=1 after the third byte.
- **Bad checksum:** bytes 00 02 00 05 EC 10 FE → `error`=1, `cpu_reset` stays 1, `loaded`=0. `rx_ready`=0 thereafter.
- **Overflow:** with MAX_WORDS=4, bytes 00 05 → `error`=1 on the cycle after the second byte. Further bytes are not accepted.
- **Stall tolerance:** the two-word frame with 0–3 random idle cycles between bytes → identical writes and release. Holding `rx_valid`=1 in S_RUN produces no writes.
- **Reset mid-frame:** bytes 00 02 00, assert `reset` for one cycle, then the full two-word frame → first write at `rom_addr`=0, and the load succeeds.
